// File: rtl/spi_burst_sequencer.sv
// Burst sequencer feeding an SPI master: a TX FIFO drives SendData/SPIGo for N words,
// and the returned words are captured into an RX FIFO after a fixed delay.
module spi_burst_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          empty, full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = empty ? '0 : mem_q[rp_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

module spi_burst_sequencer #(
  parameter int WordLen   = 8,
  parameter int FifoDepth = 16,
  parameter int CapDelay  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WordLen-1:0]         TxData,
  input  logic                       TxWrite,
  output logic                       TxFull,
  output logic [$clog2(FifoDepth):0] TxLevel,
  output logic [WordLen-1:0]         RxData,
  input  logic                       RxRead,
  output logic                       RxEmpty,
  output logic [$clog2(FifoDepth):0] RxLevel,
  input  logic                       Start,
  input  logic [$clog2(FifoDepth):0] BurstLen,
  output logic                       Busy,
  output logic                       Done,
  output logic                       StartErr,
  output logic                       TxOvf,
  output logic                       RxUnf,
  input  logic                       ErrClr,
  output logic                       SPIGo,
  output logic [WordLen-1:0]         SendData,
  input  logic                       WordFlg,
  input  logic                       TxBusy,
  input  logic [WordLen-1:0]         ReceivedData
);
  localparam int LW = $clog2(FifoDepth);
  localparam logic [LW:0] FULL_CNT = (LW+1)'(FifoDepth);
  localparam logic [LW:0] ONE      = (LW+1)'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRIME  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [LW:0]        remain_q, remain_d, len_q, len_d, cap_cnt_q, cap_cnt_d;
  logic               spigo_q, spigo_d, start_err_q, start_err_d;
  logic               tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [WordLen-1:0] send_q, send_d, tx_head;
  logic               tx_pop, rx_push, wf_acc, start_ok;
  logic [CapDelay:1]  cap_pipe_q;
  logic [CapDelay:0]  cap_pipe;

  spi_burst_fifo #(.W(WordLen), .DEPTH(FifoDepth)) u_tx (
    .clk(clk), .reset(reset), .push_i(TxWrite), .wdata_i(TxData),
    .pop_i(tx_pop), .rdata_o(tx_head), .level_o(TxLevel)
  );

  spi_burst_fifo #(.W(WordLen), .DEPTH(FifoDepth)) u_rx (
    .clk(clk), .reset(reset), .push_i(rx_push), .wdata_i(ReceivedData),
    .pop_i(RxRead), .rdata_o(RxData), .level_o(RxLevel)
  );

  assign TxFull   = (TxLevel == FULL_CNT);
  assign RxEmpty  = (RxLevel == '0);
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_FINISH);
  assign StartErr = start_err_q;
  assign TxOvf    = tx_ovf_q;
  assign RxUnf    = rx_unf_q;
  assign SPIGo    = spigo_q;
  assign SendData = send_q;

  // Reserving RX space up front means captures can never overflow mid-burst.
  assign start_ok = (BurstLen != '0) && (BurstLen <= FULL_CNT) &&
                    (TxLevel >= BurstLen) && ((FULL_CNT - RxLevel) >= BurstLen);

  assign wf_acc   = WordFlg && (state_q == S_RUN);
  assign cap_pipe = {cap_pipe_q, wf_acc};
  assign rx_push  = cap_pipe[CapDelay];

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    len_d       = len_q;
    cap_cnt_d   = rx_push ? cap_cnt_q + 1'b1 : cap_cnt_q;
    spigo_d     = spigo_q;
    send_d      = send_q;
    start_err_d = 1'b0;
    tx_pop      = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        if (start_ok) begin
          state_d   = S_PRIME;
          remain_d  = BurstLen;
          len_d     = BurstLen;
          cap_cnt_d = '0;
        end else begin
          start_err_d = 1'b1;
        end
      end
      S_PRIME: begin
        tx_pop  = 1'b1;
        send_d  = tx_head;
        spigo_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (WordFlg) begin
        remain_d = remain_q - ONE;
        if (remain_q > ONE) begin
          tx_pop = 1'b1;
          send_d = tx_head;
        end else begin
          spigo_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN:  if ((cap_cnt_q == len_q) && !TxBusy) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle error so software never loses the clear.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (ErrClr) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end else begin
      if (TxWrite && TxFull && !tx_pop) tx_ovf_d = 1'b1;
      if (RxRead && RxEmpty)            rx_unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remain_q    <= '0;
      len_q       <= '0;
      cap_cnt_q   <= '0;
      spigo_q     <= 1'b0;
      send_q      <= '0;
      start_err_q <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_unf_q    <= 1'b0;
      cap_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      len_q       <= len_d;
      cap_cnt_q   <= cap_cnt_d;
      spigo_q     <= spigo_d;
      send_q      <= send_d;
      start_err_q <= start_err_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_unf_q    <= rx_unf_d;
      cap_pipe_q  <= cap_pipe[CapDelay-1:0];
    end
  end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a simple SPI master model that
// answers each word with its bitwise inverse.
module tb_spi_burst_sequencer;
  localparam int W = 8, D = 16, CD = 2, LW = $clog2(D);

  logic clk = 0, reset = 0;
  logic [W-1:0] TxData = '0;  logic TxWrite = 0;  logic TxFull;  logic [LW:0] TxLevel;
  logic [W-1:0] RxData;       logic RxRead = 0;   logic RxEmpty; logic [LW:0] RxLevel;
  logic Start = 0; logic [LW:0] BurstLen = '0;
  logic Busy, Done, StartErr, TxOvf, RxUnf; logic ErrClr = 0;
  logic SPIGo; logic [W-1:0] SendData;
  logic WordFlg = 0, TxBusy = 0; logic [W-1:0] ReceivedData = '0;

  always #5 clk = ~clk;

  spi_burst_sequencer #(.WordLen(W), .FifoDepth(D), .CapDelay(CD)) dut (
    .clk(clk), .reset(reset), .TxData(TxData), .TxWrite(TxWrite), .TxFull(TxFull),
    .TxLevel(TxLevel), .RxData(RxData), .RxRead(RxRead), .RxEmpty(RxEmpty),
    .RxLevel(RxLevel), .Start(Start), .BurstLen(BurstLen), .Busy(Busy), .Done(Done),
    .StartErr(StartErr), .TxOvf(TxOvf), .RxUnf(RxUnf), .ErrClr(ErrClr), .SPIGo(SPIGo),
    .SendData(SendData), .WordFlg(WordFlg), .TxBusy(TxBusy), .ReceivedData(ReceivedData)
  );

  int tests = 0, fails = 0, seed = 0;
  logic [W-1:0] txm_q[$], rxm_q[$], sent_q[$];
  int done_cnt = 0, busy_done = 0, rises = 0, last_wf = 0, min_gap = 1000, tick = 0;
  logic go_prev = 0;

  typedef struct {
    int n_push; int blen; bit err; int exp_tx; int exp_rx; int n_pop;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master model: 4 cycles per word, TxBusy lingers 4 cycles after the last word.
  initial begin : master
    int cnt = 0, tail = 0; logic act = 0; logic [W-1:0] w = '0;
    forever begin
      @(negedge clk);
      WordFlg = 0;
      if (!reset) begin
        act = 0; TxBusy = 0; tail = 0;
      end else if (act) begin
        cnt++;
        if (cnt == 4) begin ReceivedData = ~w; WordFlg = 1; act = 0; tail = 4; end
      end else if (SPIGo) begin
        act = 1; cnt = 0; w = SendData; TxBusy = 1; sent_q.push_back(SendData);
      end else if (tail > 0) tail--;
      else TxBusy = 0;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      tick++;
      if (WordFlg) last_wf = tick;
      if (Done) begin
        done_cnt++;
        if (TxBusy) busy_done++;
        if (tick - last_wf < min_gap) min_gap = tick - last_wf;
      end
      if (SPIGo && !go_prev) rises++;
      go_prev = SPIGo;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [W-1:0] d);
    TxData = d; TxWrite = 1;
    @(negedge clk);
    TxWrite = 0;
    if (txm_q.size() < D) txm_q.push_back(d);
  endtask

  task automatic push_pat(input int n);
    for (int i = 0; i < n; i++) begin
      push(W'(seed * 53 + 17));
      seed++;
    end
  endtask

  task automatic start(input int b, input bit exp_err, input string tag);
    BurstLen = (LW+1)'(b); Start = 1;
    @(negedge clk);
    Start = 0;
    chk({tag, " starterr"}, StartErr, exp_err);
    chk({tag, " busy"}, Busy, !exp_err);
  endtask

  task automatic run_done(input int b, input string tag);
    int d0 = done_cnt;
    for (int i = 0; i < 1500 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, " done pulses"}, done_cnt - d0, 1);
    chk({tag, " busy after"}, Busy, 0);
    chk({tag, " sent count"}, sent_q.size(), b);
    if (sent_q.size() == b && txm_q.size() >= b) begin
      for (int k = 0; k < b; k++) begin
        logic [W-1:0] e, s;
        e = txm_q.pop_front(); s = sent_q.pop_front();
        chk({tag, " senddata"}, s, e);
        rxm_q.push_back(~e);
      end
    end else sent_q.delete();
  endtask

  task automatic pop_rx(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (rxm_q.size() > 0) chk({tag, " rxdata"}, RxData, rxm_q.pop_front());
      RxRead = 1;
      @(negedge clk);
      RxRead = 0;
    end
  endtask

  initial begin : main
    logic [W-1:0] exp_rx [3];
    int r0, wf;
    vecs[0] = '{1, 3,  1, 2,  0,  0};
    vecs[1] = '{0, 0,  1, 2,  0,  0};
    vecs[2] = '{1, 17, 1, 3,  0,  0};
    vecs[3] = '{0, 3,  0, 0,  3,  0};
    vecs[4] = '{14, 14, 1, 14, 3,  3};
    vecs[5] = '{0, 14, 0, 0,  14, 14};
    vecs[6] = '{10, 10, 0, 0, 10, 10};
    vecs[7] = '{10, 10, 0, 0, 10, 10};
    vecs[8] = '{1, 1,  0, 0,  1,  1};

    // Reset values with a write attempted during reset
    repeat (2) @(negedge clk);
    TxData = 8'h77; TxWrite = 1;
    @(negedge clk);
    TxWrite = 0;
    chk("rst spigo", SPIGo, 0);     chk("rst senddata", SendData, 0);
    chk("rst busy", Busy, 0);       chk("rst done", Done, 0);
    chk("rst starterr", StartErr, 0);
    chk("rst txovf", TxOvf, 0);     chk("rst rxunf", RxUnf, 0);
    chk("rst txfull", TxFull, 0);   chk("rst rxempty", RxEmpty, 1);
    chk("rst txlevel", TxLevel, 0); chk("rst rxlevel", RxLevel, 0);
    chk("rst rxdata", RxData, 0);
    reset = 1;
    @(negedge clk);
    chk("post rst txlevel", TxLevel, 0);

    // Basic 3-word burst
    push(8'hA5); push(8'h3C); push(8'hFF);
    chk("basic txlevel", TxLevel, 3);
    r0 = rises;
    BurstLen = 3; Start = 1;
    @(negedge clk);
    Start = 0;
    chk("basic starterr", StartErr, 0);
    chk("basic prime spigo", SPIGo, 0);
    chk("basic prime busy", Busy, 1);
    @(negedge clk);
    chk("basic spigo t+2", SPIGo, 1);
    chk("basic first send", SendData, 8'hA5);
    run_done(3, "basic");
    chk("basic spigo rises", rises - r0, 1);
    chk("basic txlevel end", TxLevel, 0);
    chk("basic rxlevel end", RxLevel, 3);
    exp_rx[0] = 8'h5A; exp_rx[1] = 8'hC3; exp_rx[2] = 8'h00;
    rxm_q.delete();
    for (int i = 0; i < 3; i++) begin
      chk("basic rx order", RxData, exp_rx[i]);
      RxRead = 1;
      @(negedge clk);
      RxRead = 0;
    end
    chk("basic rxempty", RxEmpty, 1);

    // Sticky flags, then a full-depth burst
    push_pat(17);
    chk("ovf flag", TxOvf, 1);
    chk("ovf txlevel", TxLevel, 16);
    chk("ovf txfull", TxFull, 1);
    RxRead = 1;
    @(negedge clk);
    RxRead = 0;
    chk("unf flag", RxUnf, 1);
    ErrClr = 1;
    @(negedge clk);
    ErrClr = 0;
    chk("clr txovf", TxOvf, 0);
    chk("clr rxunf", RxUnf, 0);
    start(16, 0, "full");
    chk("full txfull prime", TxFull, 1);
    @(negedge clk);
    chk("full txfull popped", TxFull, 0);
    chk("full txlevel popped", TxLevel, 15);
    run_done(16, "full");
    chk("full rxlevel", RxLevel, 16);
    push_pat(1);
    start(1, 1, "rx nospace");
    pop_rx(16, "full");

    // Table: acceptance rules, levels and data order across pointer wrap
    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      push_pat(vecs[v].n_push);
      chk({tag, " txfull"}, TxFull, txm_q.size() == D);
      start(vecs[v].blen, vecs[v].err, tag);
      if (!vecs[v].err) run_done(vecs[v].blen, tag);
      else repeat (2) @(negedge clk);
      chk({tag, " txlevel"}, TxLevel, vecs[v].exp_tx);
      chk({tag, " rxlevel"}, RxLevel, vecs[v].exp_rx);
      pop_rx(vecs[v].n_pop, tag);
    end

    // Reset after the second WordFlg of a 4-word burst
    push_pat(4);
    start(4, 0, "abort");
    wf = 0;
    for (int i = 0; i < 200 && wf < 2; i++) begin
      @(posedge clk); #1;
      if (WordFlg) wf++;
    end
    chk("abort wordflg seen", wf, 2);
    @(negedge clk);
    reset = 0;
    r0 = done_cnt;
    #1;
    chk("abort spigo", SPIGo, 0);
    chk("abort busy", Busy, 0);
    chk("abort txlevel", TxLevel, 0);
    chk("abort rxlevel", RxLevel, 0);
    chk("abort rxempty", RxEmpty, 1);
    repeat (4) @(negedge clk);
    reset = 1;
    repeat (10) @(negedge clk);
    chk("abort no done", done_cnt - r0, 0);
    txm_q.delete(); rxm_q.delete(); sent_q.delete();
    push_pat(2);
    start(2, 0, "after abort");
    run_done(2, "after abort");
    chk("after abort rxlevel", RxLevel, 2);
    pop_rx(2, "after abort");

    chk("done never with txbusy", busy_done, 0);
    chk("done gap ok", min_gap >= CD + 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
